// File: rtl/axis_demux_4.sv
// AXI4-Stream 1:4 frame demux: each whole frame goes to the port chosen by select at frame start, or is dropped.
// Latency 1; input tready is registered, and a one-entry skid buffer keeps throughput at one beat per cycle.
module axis_demux_4 #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic [USER_WIDTH-1:0] input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
  output logic                  output_0_axis_tvalid,
  input  logic                  output_0_axis_tready,
  output logic                  output_0_axis_tlast,
  output logic [USER_WIDTH-1:0] output_0_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
  output logic                  output_1_axis_tvalid,
  input  logic                  output_1_axis_tready,
  output logic                  output_1_axis_tlast,
  output logic [USER_WIDTH-1:0] output_1_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_2_axis_tdata,
  output logic                  output_2_axis_tvalid,
  input  logic                  output_2_axis_tready,
  output logic                  output_2_axis_tlast,
  output logic [USER_WIDTH-1:0] output_2_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_3_axis_tdata,
  output logic                  output_3_axis_tvalid,
  input  logic                  output_3_axis_tready,
  output logic                  output_3_axis_tlast,
  output logic [USER_WIDTH-1:0] output_3_axis_tuser,
  input  logic                  enable,
  input  logic [1:0]            select,
  input  logic                  drop
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_next;
  logic [1:0]            select_reg, select_next;
  logic                  drop_reg, drop_next;
  logic                  tready_reg, tready_next;
  logic                  ready_early, port_block;

  logic                  out_valid, skid_valid;
  logic [1:0]            out_port, skid_port;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  out_last, skid_last;
  logic [USER_WIDTH-1:0] out_user, skid_user;
  logic [USER_WIDTH-1:0] user_q;

  logic [3:0]            out_ready;
  logic                  out_ready_sel, accept, store_in;

  assign out_ready     = {output_3_axis_tready, output_2_axis_tready,
                          output_1_axis_tready, output_0_axis_tready};
  assign out_ready_sel = out_ready[out_port];
  assign accept        = input_axis_tvalid & tready_reg;
  assign store_in      = accept & ~drop_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      select_reg <= 2'd0;
      drop_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      select_reg <= select_next;
      drop_reg   <= drop_next;
    end
  end

  always_comb begin
    state_next  = state;
    select_next = select_reg;
    drop_next   = drop_reg;
    case (state)
      IDLE: begin
        if (enable && input_axis_tvalid) begin
          state_next  = ACTIVE;
          select_next = select;
          drop_next   = drop;
        end
      end
      ACTIVE: begin
        if (accept && input_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beats still held for a different port must leave before the new frame may enter.
  always_comb begin
    ready_early = out_ready_sel | (~skid_valid & (~out_valid | ~input_axis_tvalid));
    port_block  = (out_valid & (out_port != select_next)) |
                  (skid_valid & (skid_port != select_next));
    tready_next = (state_next == ACTIVE) & (drop_next | (ready_early & ~port_block));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tready_reg <= 1'b0;
      out_valid  <= 1'b0;
      out_port   <= 2'd0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_user   <= '0;
      skid_valid <= 1'b0;
      skid_port  <= 2'd0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_user  <= '0;
    end else begin
      tready_reg <= tready_next;
      if (!out_valid || out_ready_sel) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_port   <= skid_port;
          out_data   <= skid_data;
          out_last   <= skid_last;
          out_user   <= skid_user;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= store_in;
          if (store_in) begin
            out_port <= select_reg;
            out_data <= input_axis_tdata;
            out_last <= input_axis_tlast;
            out_user <= input_axis_tuser;
          end
        end
      end else if (store_in) begin
        skid_valid <= 1'b1;
        skid_port  <= select_reg;
        skid_data  <= input_axis_tdata;
        skid_last  <= input_axis_tlast;
        skid_user  <= input_axis_tuser;
      end
    end
  end

  assign user_q            = (USER_ENABLE != 0) ? out_user : '0;
  assign input_axis_tready = tready_reg;

  assign output_0_axis_tvalid = out_valid & (out_port == 2'd0);
  assign output_1_axis_tvalid = out_valid & (out_port == 2'd1);
  assign output_2_axis_tvalid = out_valid & (out_port == 2'd2);
  assign output_3_axis_tvalid = out_valid & (out_port == 2'd3);

  assign output_0_axis_tdata = out_data;
  assign output_1_axis_tdata = out_data;
  assign output_2_axis_tdata = out_data;
  assign output_3_axis_tdata = out_data;
  assign output_0_axis_tlast = out_last;
  assign output_1_axis_tlast = out_last;
  assign output_2_axis_tlast = out_last;
  assign output_3_axis_tlast = out_last;
  assign output_0_axis_tuser = user_q;
  assign output_1_axis_tuser = user_q;
  assign output_2_axis_tuser = user_q;
  assign output_3_axis_tuser = user_q;

endmodule
